// File: rtl/line_code_pkg.sv
// Shared types and constants for the multi-lane line code converter.
package line_code_pkg;

  typedef enum logic [1:0] {
    PASS     = 2'd0,
    NRZI_ENC = 2'd1,
    NRZI_DEC = 2'd2,
    TWOS_NEG = 2'd3
  } conv_mode_t;

  // Idle line level for NRZI encode/decode state.
  localparam logic LVL_RESET = 1'b1;

endpackage

// File: rtl/line_code_lane.sv
// One lane: NRZI level, NRZI previous bit, two's-complement seen_one flag,
// and the registered output bit. The parity accumulator exists only when
// LCC_PARITY_EN is defined.
module line_code_lane
  import line_code_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       word_start,
  input  logic       sof_load,
  input  conv_mode_t mode_eff,
  input  logic       x,
`ifdef LCC_PARITY_EN
  input  logic       word_end,
  output logic       parity,
`endif
  output logic       z
);

  logic lvl_q, lvl_d;
  logic prev_q, prev_d;
  logic seen_q, seen_d;
  logic z_q, z_d;

  logic eff_lvl, eff_prev, eff_seen;
  logic conv_bit;

`ifdef LCC_PARITY_EN
  logic acc_q, acc_d;
  logic par_q, par_d;
  logic eff_acc;
`endif

  // Conversion of the current bit; word-start clearing and sof reload
  // apply before the bit is converted, so the first bit sees fresh state.
  always_comb begin
    eff_lvl  = sof_load   ? LVL_RESET : lvl_q;
    eff_prev = sof_load   ? LVL_RESET : prev_q;
    eff_seen = word_start ? 1'b0      : seen_q;

    lvl_d    = lvl_q;
    prev_d   = prev_q;
    seen_d   = seen_q;
    z_d      = z_q;
    conv_bit = x;

    if (in_valid) begin
      lvl_d  = eff_lvl;
      prev_d = eff_prev;
      seen_d = eff_seen;
      unique case (mode_eff)
        PASS: conv_bit = x;
        NRZI_ENC: begin
          conv_bit = x ? eff_lvl : ~eff_lvl;
          lvl_d    = conv_bit;
        end
        NRZI_DEC: begin
          conv_bit = (x == eff_prev);
          prev_d   = x;
        end
        TWOS_NEG: begin
          conv_bit = eff_seen ? ~x : x;
          seen_d   = eff_seen | x;
        end
        default: conv_bit = x;
      endcase
      z_d = conv_bit;
    end
  end

  // Lane state and output bit registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q  <= LVL_RESET;
      prev_q <= LVL_RESET;
      seen_q <= 1'b0;
      z_q    <= 1'b1;
    end else begin
      lvl_q  <= lvl_d;
      prev_q <= prev_d;
      seen_q <= seen_d;
      z_q    <= z_d;
    end
  end

  assign z = z_q;

`ifdef LCC_PARITY_EN
  // Running XOR of emitted bits; published on the last bit of the word.
  always_comb begin
    eff_acc = word_start ? 1'b0 : acc_q;
    acc_d   = acc_q;
    par_d   = par_q;
    if (in_valid) begin
      acc_d = eff_acc ^ conv_bit;
      if (word_end) par_d = acc_d;
    end
  end

  // Parity accumulator and published parity registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 1'b0;
      par_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      par_q <= par_d;
    end
  end

  assign parity = par_q;
`endif

endmodule

// File: rtl/line_code_converter.sv
// Multi-lane serial line code converter (PASS / NRZI encode / NRZI decode /
// serial two's-complement negation), mode latched at each word start.
// Optional feature macro: LCC_PARITY_EN adds a per-lane parity output.
module line_code_converter
  import line_code_pkg::*;
#(
  parameter int CH     = 4,
  parameter int WORD_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    mode,
  input  logic          in_valid,
  input  logic          sof,
  input  logic [CH-1:0] x,
  output logic          out_valid,
  output logic [CH-1:0] z,
  output logic          word_done,
  output logic          busy
`ifdef LCC_PARITY_EN
  ,
  output logic [CH-1:0] parity
`endif
);

  localparam int CNT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  conv_mode_t       mode_q, mode_d;
  logic             out_valid_q, out_valid_d;
  logic             word_done_q, word_done_d;

  logic       word_start;
  logic       sof_load;
  conv_mode_t mode_eff;

  // Word framing: word start, effective mode and next counter value.
  // A sof always restarts, so the bit it carries is bit 0 of a new word.
  always_comb begin
    word_start  = in_valid & ((cnt_q == '0) | sof);
    sof_load    = in_valid & sof;
    mode_eff    = word_start ? conv_mode_t'(mode) : mode_q;
    mode_d      = mode_eff;
    word_done_d = in_valid & (cnt_q == CNT_LAST) & ~sof;
    out_valid_d = in_valid;
    cnt_d       = cnt_q;
    if (in_valid) begin
      if (sof)                    cnt_d = CNT_W'(1);
      else if (cnt_q == CNT_LAST) cnt_d = '0;
      else                        cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter, latched mode and output qualifier registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      mode_q      <= PASS;
      out_valid_q <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      word_done_q <= word_done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign word_done = word_done_q;
  assign busy      = (cnt_q != '0);

  for (genvar i = 0; i < CH; i++) begin : g_lane
    line_code_lane u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .word_start (word_start),
      .sof_load   (sof_load),
      .mode_eff   (mode_eff),
      .x          (x[i]),
`ifdef LCC_PARITY_EN
      .word_end   (word_done_d),
      .parity     (parity[i]),
`endif
      .z          (z[i])
    );
  end

endmodule

// File: tb/tb_line_code_converter.sv
// Self-checking bench for line_code_converter: a behavioural model pushes
// expected outputs into a queue as stimulus is driven; each scenario task
// pops and compares, and also checks hand-derived constants.
module tb_line_code_converter;

  localparam int CH     = 4;
  localparam int WORD_W = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    mode;
  logic          in_valid;
  logic          sof;
  logic [CH-1:0] x;
  logic          out_valid;
  logic [CH-1:0] z;
  logic          word_done;
  logic          busy;
`ifdef LCC_PARITY_EN
  logic [CH-1:0] parity;
`endif

  always #5 clk = ~clk;

  line_code_converter #(.CH(CH), .WORD_W(WORD_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .sof       (sof),
    .x         (x),
    .out_valid (out_valid),
    .z         (z),
    .word_done (word_done),
    .busy      (busy)
`ifdef LCC_PARITY_EN
    ,
    .parity    (parity)
`endif
  );

  typedef struct packed {
    logic [CH-1:0] z;
    logic          wd;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  int            m_cnt;
  logic [1:0]    m_mode;
  logic [CH-1:0] m_lvl, m_prev, m_seen, m_z, m_acc, m_par;

  task automatic model_reset();
    m_cnt  = 0;
    m_mode = 2'd0;
    m_lvl  = '1;
    m_prev = '1;
    m_seen = '0;
    m_z    = '1;
    m_acc  = '0;
    m_par  = '0;
    exp_q.delete();
  endtask

  // Drive one cycle; for a valid cycle, advance the model and queue the
  // expected registered output. Returns at posedge + 1.
  task automatic drive(input logic iv, input logic s, input logic [1:0] m,
                       input logic [CH-1:0] xv);
    logic       ws;
    logic [1:0] em;
    logic       wd;
    in_valid = iv;
    sof      = s;
    mode     = m;
    x        = xv;
    if (iv) begin
      ws = (m_cnt == 0) || s;
      em = ws ? m : m_mode;
      if (ws) m_mode = m;
      for (int i = 0; i < CH; i++) begin
        if (ws) begin
          m_seen[i] = 1'b0;
          m_acc[i]  = 1'b0;
        end
        if (s) begin
          m_lvl[i]  = 1'b1;
          m_prev[i] = 1'b1;
        end
        case (em)
          2'd0: m_z[i] = xv[i];
          2'd1: begin
            if (!xv[i]) m_lvl[i] = ~m_lvl[i];
            m_z[i] = m_lvl[i];
          end
          2'd2: begin
            m_z[i]    = (xv[i] == m_prev[i]);
            m_prev[i] = xv[i];
          end
          default: begin
            m_z[i]    = m_seen[i] ? ~xv[i] : xv[i];
            m_seen[i] = m_seen[i] | xv[i];
          end
        endcase
        m_acc[i] = m_acc[i] ^ m_z[i];
      end
      wd = (m_cnt == WORD_W - 1) && !s;
      if (wd) m_par = m_acc;
      m_cnt = s ? 1 : ((m_cnt == WORD_W - 1) ? 0 : m_cnt + 1);
      exp_q.push_back('{z: m_z, wd: wd});
    end
    @(posedge clk);
    #1;
  endtask

  logic [CH-1:0] enc_x [5];
  logic [CH-1:0] enc_z [5];

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sof      = 1'b0;
    mode     = 2'd0;
    x        = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (z !== '1) $display("FAIL reset_z: got %b want %b", z, {CH{1'b1}}); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (word_done !== 1'b0) $display("FAIL reset_word_done: got %b want 0", word_done); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_nrzi_enc();
    logic [4:0] lane0_z;
    exp_t e;
    lane0_z  = 5'b01101;  // time order bit0..bit4 = 1,0,1,1,0
    enc_x[0] = 4'b0111;
    enc_x[1] = 4'b1010;
    enc_x[2] = 4'b0100;
    enc_x[3] = 4'b1101;
    enc_x[4] = 4'b0010;
    for (int t = 0; t < 5; t++) begin
      drive(1'b1, (t == 0), 2'd1, enc_x[t]);
      n_total++;
      if (out_valid !== 1'b1 || exp_q.size() == 0) begin
        $display("FAIL enc_out_valid t%0d: got %b want 1", t, out_valid);
      end else begin
        n_pass++;
        e = exp_q.pop_front();
        n_total++; if (z !== e.z) $display("FAIL enc_z t%0d: got %b want %b", t, z, e.z); else n_pass++;
        n_total++; if (word_done !== e.wd) $display("FAIL enc_wd t%0d: got %b want %b", t, word_done, e.wd); else n_pass++;
      end
      n_total++; if (z[0] !== lane0_z[t]) $display("FAIL enc_lane0 t%0d: got %b want %b", t, z[0], lane0_z[t]); else n_pass++;
      enc_z[t] = z;
    end
  endtask

  task automatic test_nrzi_dec();
    exp_t e;
    for (int t = 0; t < 5; t++) begin
      drive(1'b1, (t == 0), 2'd2, enc_z[t]);
      n_total++;
      if (out_valid !== 1'b1 || exp_q.size() == 0) begin
        $display("FAIL dec_out_valid t%0d: got %b want 1", t, out_valid);
      end else begin
        n_pass++;
        e = exp_q.pop_front();
        n_total++; if (z !== e.z) $display("FAIL dec_z t%0d: got %b want %b", t, z, e.z); else n_pass++;
      end
      n_total++; if (z !== enc_x[t]) $display("FAIL dec_roundtrip t%0d: got %b want %b", t, z, enc_x[t]); else n_pass++;
    end
  endtask

  task automatic test_twos_neg();
    logic [7:0] v0, v1, v2, v3, neg0;
    exp_t e;
    v0 = 8'h14; v1 = 8'h00; v2 = 8'hA5; v3 = 8'hFF; neg0 = 8'hEC;
    for (int t = 0; t < WORD_W; t++) begin
      drive(1'b1, (t == 0), 2'd3, {v3[t], v2[t], v1[t], v0[t]});
      n_total++;
      if (out_valid !== 1'b1 || exp_q.size() == 0) begin
        $display("FAIL neg_out_valid t%0d: got %b want 1", t, out_valid);
      end else begin
        n_pass++;
        e = exp_q.pop_front();
        n_total++; if (z !== e.z) $display("FAIL neg_z t%0d: got %b want %b", t, z, e.z); else n_pass++;
      end
      n_total++; if (z[0] !== neg0[t]) $display("FAIL neg_0x14 t%0d: got %b want %b", t, z[0], neg0[t]); else n_pass++;
      n_total++; if (z[1] !== 1'b0) $display("FAIL neg_0x00 t%0d: got %b want 0", t, z[1]); else n_pass++;
      n_total++; if (word_done !== (t == WORD_W - 1)) $display("FAIL neg_word_done t%0d: got %b want %b", t, word_done, (t == WORD_W - 1)); else n_pass++;
    end
`ifdef LCC_PARITY_EN
    n_total++; if (parity !== m_par) $display("FAIL neg_parity: got %b want %b", parity, m_par); else n_pass++;
`endif
  endtask

  task automatic test_mode_switch();
    logic [CH-1:0] xv;
    exp_t e;
    for (int t = 0; t < 2 * WORD_W; t++) begin
      xv    = CH'($urandom);
      xv[0] = 1'b0;
      xv[1] = (t == 0) || (t == WORD_W);
      drive(1'b1, (t == 0), (t < 3) ? 2'd1 : 2'd3, xv);
      n_total++;
      if (out_valid !== 1'b1 || exp_q.size() == 0) begin
        $display("FAIL sw_out_valid t%0d: got %b want 1", t, out_valid);
      end else begin
        n_pass++;
        e = exp_q.pop_front();
        n_total++; if (z !== e.z) $display("FAIL sw_z t%0d: got %b want %b", t, z, e.z); else n_pass++;
        n_total++; if (word_done !== e.wd) $display("FAIL sw_wd t%0d: got %b want %b", t, word_done, e.wd); else n_pass++;
      end
      if (t < WORD_W) begin
        n_total++; if (z[0] !== t[0]) $display("FAIL sw_old_mode t%0d: got %b want %b", t, z[0], t[0]); else n_pass++;
      end
      if (t == WORD_W) begin
        n_total++; if (z[1] !== 1'b1) $display("FAIL sw_new_mode_bit0: got %b want 1", z[1]); else n_pass++;
      end
    end
  endtask

  task automatic test_gaps();
    logic [7:0] v0, neg0, got0;
    logic [CH-1:0] xv;
    int wd_count;
    exp_t e;
    v0 = 8'h14; neg0 = 8'hEC; got0 = '0;
    for (int t = 0; t < WORD_W; t++) begin
      xv    = CH'($urandom);
      xv[0] = v0[t];
      drive(1'b1, (t == 0), 2'd3, xv);
      n_total++;
      if (out_valid !== 1'b1 || exp_q.size() == 0) begin
        $display("FAIL gap_out_valid t%0d: got %b want 1", t, out_valid);
      end else begin
        n_pass++;
        e = exp_q.pop_front();
        n_total++; if (z !== e.z) $display("FAIL gap_z t%0d: got %b want %b", t, z, e.z); else n_pass++;
        n_total++; if (word_done !== e.wd) $display("FAIL gap_wd t%0d: got %b want %b", t, word_done, e.wd); else n_pass++;
      end
      got0[t] = z[0];
      if (t < WORD_W - 1) begin
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
          drive(1'b0, 1'b0, 2'($urandom), CH'($urandom));
          n_total++; if (out_valid !== 1'b0) $display("FAIL gap_idle_valid t%0d: got %b want 0", t, out_valid); else n_pass++;
          n_total++; if (word_done !== 1'b0) $display("FAIL gap_idle_wd t%0d: got %b want 0", t, word_done); else n_pass++;
          n_total++; if (z !== m_z) $display("FAIL gap_idle_hold t%0d: got %b want %b", t, z, m_z); else n_pass++;
        end
      end
    end
    n_total++; if (got0 !== neg0) $display("FAIL gap_word: got %h want %h", got0, neg0); else n_pass++;

    // Word aborted by sof at cnt=5; only the restarted word completes.
    wd_count = 0;
    for (int t = 0; t < 5 + WORD_W; t++) begin
      drive(1'b1, (t == 0) || (t == 5), 2'd1, CH'($urandom));
      if (t == 4) begin
        n_total++; if (busy !== 1'b1) $display("FAIL abort_busy: got %b want 1", busy); else n_pass++;
      end
      n_total++;
      if (out_valid !== 1'b1 || exp_q.size() == 0) begin
        $display("FAIL abort_out_valid t%0d: got %b want 1", t, out_valid);
      end else begin
        n_pass++;
        e = exp_q.pop_front();
        n_total++; if (z !== e.z) $display("FAIL abort_z t%0d: got %b want %b", t, z, e.z); else n_pass++;
      end
      if (word_done === 1'b1) wd_count++;
    end
    n_total++; if (wd_count !== 1) $display("FAIL abort_wd_count: got %0d want 1", wd_count); else n_pass++;
    n_total++; if (word_done !== 1'b1) $display("FAIL abort_wd_last: got %b want 1", word_done); else n_pass++;
  endtask

  task automatic test_async_reset();
    exp_t e;
    for (int t = 0; t < 3; t++) begin
      drive(1'b1, (t == 0), 2'd0, '0);
    end
    exp_q.delete();
    n_total++; if (z !== '0) $display("FAIL ar_pre_z: got %b want %b", z, {CH{1'b0}}); else n_pass++;
    #3;
    rst_n = 1'b0;
    #1;
    n_total++; if (z !== '1) $display("FAIL ar_z: got %b want %b", z, {CH{1'b1}}); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL ar_out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL ar_busy: got %b want 0", busy); else n_pass++;
    in_valid = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Counter restarted at 0: a word without sof completes after WORD_W bits.
    for (int t = 0; t < WORD_W; t++) begin
      drive(1'b1, 1'b0, 2'd0, CH'($urandom));
      n_total++;
      if (out_valid !== 1'b1 || exp_q.size() == 0) begin
        $display("FAIL ar_out_valid2 t%0d: got %b want 1", t, out_valid);
      end else begin
        n_pass++;
        e = exp_q.pop_front();
        n_total++; if (z !== e.z) $display("FAIL ar_z2 t%0d: got %b want %b", t, z, e.z); else n_pass++;
        n_total++; if (word_done !== e.wd) $display("FAIL ar_wd t%0d: got %b want %b", t, word_done, e.wd); else n_pass++;
      end
    end
    drive(1'b0, 1'b0, 2'd0, '0);
  endtask

  initial begin
    test_reset();
    test_nrzi_enc();
    test_nrzi_dec();
    test_twos_neg();
    test_mode_switch();
    test_gaps();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
